enemy_control: RTL and testbench
================================

# enemy_control

Per-enemy sequencing FSM that drives the state strobes (`init`, `idle`, `gen_move`, `apply_move`, `draw`) of one enemy movement/draw unit. It paces the enemy from a frame-tick divider, requests the shared VGA write port from the top-level arbiter before each redraw, and waits for the enemy's `draw_done`. It sits directly upstream of the enemy unit, between the game-level FSM and the enemy.

## Interface
- `FRAME_TICKS`, default 833334: clock cycles per frame tick (50 MHz / 60). Minimum 8.
- `MOVE_DIV`, default 4: a move happens on every MOVE_DIV-th consumed tick. Range 1..16.
- `DRAW_TIMEOUT`, default 512: watchdog limit, in cycles, for a `draw_done` wait.
- `clock` in 1: system clock.
- `reset` in 1: reset reset, synchronous, active-high; clock clock.
- `respawn` in 1: pulse; re-initialise the enemy.
- `draw_grant` in 1: VGA arbiter grant, level.
- `draw_done` in 1: from the enemy unit, level.
- `init`, `idle`, `gen_move`, `apply_move`, `draw` out 1 each: state strobes to the enemy. At most one is high.
- `draw_request` out 1: VGA port request.
- `frame_count` out 16: completed draws.
- `overrun` out 8: dropped ticks, saturating.
- `draw_error` out 1: sticky watchdog flag.

## Operation
- States: INIT, IDLE, GEN, APPLY, REQ, DRAW. Outputs are a Moore decode of the registered state, except the counters.
- Strobe decode:
  - INIT: `init`=1.
  - IDLE: `idle`=1.
  - GEN: `gen_move`=1.
  - APPLY: `apply_move`=1.
  - REQ: `idle`=1, `draw_request`=1.
  - DRAW: `draw`=1, `draw_request`=1.
- Tick divider: a free-running counter runs 0..FRAME_TICKS-1. `tick` pulses for 1 cycle at the wrap.
- Pending tick:
  - A one-deep `pend` flag is set by `tick`.
  - `pend` is cleared when IDLE consumes it.
  - A `tick` arriving while `pend`=1 and the tick is not being consumed that cycle increments `overrun`, which saturates at 255.
- Respawn: a `resp_pend` flag is set by `respawn` and cleared on entry to INIT.
- Transitions:
  - INIT -> IDLE after 1 cycle.
  - IDLE:
    - If `resp_pend` -> INIT. Respawn has priority over ticks.
    - Else if `pend` or `tick`: consume the tick. If `phase`==MOVE_DIV-1 -> GEN, else -> REQ. `phase` increments modulo MOVE_DIV.
    - Else stay.
  - GEN -> APPLY -> REQ, 1 cycle each.
  - REQ -> DRAW on `draw_grant`; otherwise hold.
  - DRAW:
    - On `draw_done` -> IDLE and `frame_count`+1, wrapping at 16 bits.
    - `respawn` during GEN, APPLY, REQ or DRAW is only latched; it is acted on in IDLE.
- `draw_done` is ignored outside DRAW.
- REQ drives `idle`, so the enemy clears any stale `draw_done` before DRAW begins.
- `draw_grant` dropping mid-DRAW is ignored. The block stays in DRAW until `draw_done`.

## Timing
- Reset values:
  - State INIT, so `init`=1 during reset and on the first cycle after it.
  - All other strobes 0, `draw_request`=0.
  - `frame_count`=0, `overrun`=0, `draw_error`=0.
  - Divider, `phase`, `pend` and `resp_pend` all cleared.
- Reset mid-operation from any state: same values on the next edge. No draw completes.
- Move-frame latency: tick consumed at cycle t (IDLE) -> GEN at t+1, APPLY at t+2, REQ at t+3. DRAW starts at t+4 at the earliest, when `draw_grant` is high at t+3.
- Redraw-only latency: tick consumed at t -> REQ at t+1.
- Leaving DRAW: `draw_done` high at cycle d -> IDLE at d+1, `frame_count` updates at d+1.
- Simultaneous events:
  - `tick` and `respawn` in the same IDLE cycle: go to INIT and set `pend`. The tick is consumed on return to IDLE.

## Configuration
- `ENEMY_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts cycles in DRAW.
  - After DRAW_TIMEOUT cycles without `draw_done`: go to IDLE, set `draw_error` (sticky until reset), leave `frame_count` unchanged.
- `ENEMY_CTRL_TIMEOUT_EN` undefined:
  - No watchdog; DRAW waits indefinitely.
  - `draw_error` is tied to 0.

## Test plan
All scenarios use FRAME_TICKS=16, MOVE_DIV=2, DRAW_TIMEOUT=300.

- Reset release, grant tied high, enemy model asserts `draw_done` 256 cycles after `draw` rises:
  - `init` is high for 1 cycle.
  - First tick gives REQ then DRAW with no GEN (`phase` 0).
  - Second tick gives GEN, APPLY, REQ, DRAW.
  - `frame_count`=2 after both draws.
- `draw_grant` held low for 40 cycles in REQ:
  - `draw_request` stays 1 and `draw` stays 0.
  - Grant rises at cycle g -> `draw`=1 at g+1.
- `draw_done` delayed to 300 cycles, so ticks keep arriving:
  - First extra tick sets `pend`.
  - Each further tick increments `overrun` (`overrun`=17 after 300 cycles).
  - Pending tick consumed in the cycle immediately after returning to IDLE.
- `respawn` pulsed mid-DRAW:
  - DRAW completes.
  - IDLE -> INIT (`init` 1 cycle) -> IDLE.
  - `frame_count` incremented once.
- With `ENEMY_CTRL_TIMEOUT_EN` defined, `draw_done` never asserted:
  - IDLE after 300 DRAW cycles.
  - `draw_error`=1 and stays 1.
  - `frame_count` unchanged.
- `reset` asserted in APPLY:
  - Next cycle: state INIT, all counters 0, `draw_error`=0.

Source files
------------

// File: rtl/enemy_control_if.sv
// enemy_control_if
//
// Groups the handshake between the enemy sequencer, the enemy movement/draw
// unit it strobes, and the shared VGA write-port arbiter.
//
// Signals:
//   init, idle, gen_move, apply_move, draw : state strobes to the enemy unit
//   draw_done                              : enemy unit finished its redraw
//   draw_request                           : request for the VGA write port
//   draw_grant                             : VGA arbiter grant (level)
//
// Modports:
//   master : the sequencer (enemy_control) side
//   slave  : the enemy unit / arbiter side
interface enemy_control_if;
    logic init;
    logic idle;
    logic gen_move;
    logic apply_move;
    logic draw;
    logic draw_done;
    logic draw_request;
    logic draw_grant;

    modport master (
        output init,
        output idle,
        output gen_move,
        output apply_move,
        output draw,
        output draw_request,
        input  draw_done,
        input  draw_grant
    );

    modport slave (
        input  init,
        input  idle,
        input  gen_move,
        input  apply_move,
        input  draw,
        input  draw_request,
        output draw_done,
        output draw_grant
    );
endinterface

// File: rtl/enemy_control.sv
// enemy_control
//
// Per-enemy sequencing FSM. Paces one enemy from a frame-tick divider, moves
// it on every MOVE_DIV-th consumed tick, requests the shared VGA write port
// before each redraw and waits for the enemy's draw_done.
//
// Parameters:
//   FRAME_TICKS  : clock cycles per frame tick (>= 8)
//   MOVE_DIV     : move on every MOVE_DIV-th consumed tick (1..16)
//   DRAW_TIMEOUT : watchdog limit in cycles for a draw_done wait
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   respawn      : pulse, re-initialise the enemy
//   bus          : enemy_control_if.master (strobes, draw_done,
//                  draw_request, draw_grant)
//   frame_count  : completed draws, wraps at 16 bits
//   overrun      : dropped frame ticks, saturates at 255
//   draw_error   : sticky watchdog flag
//
// Build option:
//   ENEMY_CTRL_TIMEOUT_EN : when defined, a watchdog abandons a DRAW after
//   DRAW_TIMEOUT cycles without draw_done and sets draw_error. When
//   undefined, DRAW waits indefinitely and draw_error is tied to 0.
module enemy_control #(
    parameter int FRAME_TICKS  = 833334,
    parameter int MOVE_DIV     = 4,
    parameter int DRAW_TIMEOUT = 512
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   respawn,
    enemy_control_if.master        bus,
    output logic [15:0]            frame_count,
    output logic [7:0]             overrun,
    output logic                   draw_error
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_GEN,
        ST_APPLY,
        ST_REQ,
        ST_DRAW
    } state_t;

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST  = CW'(FRAME_TICKS - 1);
    localparam logic [3:0]    PHASE_LAST = 4'(MOVE_DIV - 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    phase;
    logic          pend;
    logic          resp_pend;
    logic          consume;
    logic          draw_timeout;
    logic [5:0]    strobe_q;

    // Strobes are registered; bit order {init, idle, gen_move, apply_move,
    // draw, draw_request}.
    assign bus.init         = strobe_q[5];
    assign bus.idle         = strobe_q[4];
    assign bus.gen_move     = strobe_q[3];
    assign bus.apply_move   = strobe_q[2];
    assign bus.draw         = strobe_q[1];
    assign bus.draw_request = strobe_q[0];

    assign tick = (div_cnt == TICK_LAST);

    // Moore decode, applied to the next state so the strobes register
    // alongside the state itself. REQ raises idle so the enemy clears any
    // stale draw_done before DRAW begins.
    function automatic logic [5:0] decode(input state_t s);
        logic [5:0] v;
        v = 6'b000000;
        case (s)
            ST_INIT:  v = 6'b100000;
            ST_IDLE:  v = 6'b010000;
            ST_GEN:   v = 6'b001000;
            ST_APPLY: v = 6'b000100;
            ST_REQ:   v = 6'b010001;
            ST_DRAW:  v = 6'b000011;
            default:  v = 6'b100000;
        endcase
        return v;
    endfunction

    // Next-state logic. A respawn seen in IDLE, either latched earlier or
    // arriving this very cycle, beats any tick; the tick then stays pending
    // until the enemy is back in IDLE.
    always_comb begin
        next_state = state;
        consume    = 1'b0;
        case (state)
            ST_INIT:  next_state = ST_IDLE;
            ST_IDLE: begin
                if (resp_pend || respawn) begin
                    next_state = ST_INIT;
                end else if (pend || tick) begin
                    consume    = 1'b1;
                    next_state = (phase == PHASE_LAST) ? ST_GEN : ST_REQ;
                end
            end
            ST_GEN:   next_state = ST_APPLY;
            ST_APPLY: next_state = ST_REQ;
            ST_REQ: begin
                if (bus.draw_grant) begin
                    next_state = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (bus.draw_done || draw_timeout) begin
                    next_state = ST_IDLE;
                end
            end
            default:  next_state = ST_INIT;
        endcase
    end

    // Main sequencer: state, strobes, divider, move phase, pending flags and
    // the frame/overrun counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_INIT;
            strobe_q    <= 6'b100000;
            div_cnt     <= '0;
            phase       <= '0;
            pend        <= 1'b0;
            resp_pend   <= 1'b0;
            frame_count <= '0;
            overrun     <= '0;
        end else begin
            state    <= next_state;
            strobe_q <= decode(next_state);
            div_cnt  <= tick ? '0 : div_cnt + CW'(1);

            if (consume) begin
                phase <= (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;
            end

            // Consuming with both a pending tick and a fresh one keeps the
            // fresh one pending rather than dropping it.
            if (consume) begin
                pend <= pend && tick;
            end else if (tick) begin
                pend <= 1'b1;
                if (pend && overrun != 8'hFF) begin
                    overrun <= overrun + 8'd1;
                end
            end

            if (next_state == ST_INIT && state != ST_INIT) begin
                resp_pend <= 1'b0;
            end else if (respawn) begin
                resp_pend <= 1'b1;
            end

            if (state == ST_DRAW && bus.draw_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef ENEMY_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(DRAW_TIMEOUT + 1);

    logic [WW-1:0] wd_cnt;
    logic          err_q;

    // The watchdog fires on the DRAW_TIMEOUT-th DRAW cycle; a draw_done in
    // that same cycle still counts as a normal completion.
    assign draw_timeout = (state == ST_DRAW) && !bus.draw_done &&
                          (wd_cnt == WW'(DRAW_TIMEOUT - 1));
    assign draw_error   = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ST_DRAW && next_state == ST_DRAW) begin
                wd_cnt <= wd_cnt + WW'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (draw_timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign draw_timeout = 1'b0;
    assign draw_error   = 1'b0;
`endif

endmodule

// File: tb/tb_enemy_control.sv
// tb_enemy_control
//
// Testbench for enemy_control with FRAME_TICKS=16, MOVE_DIV=2,
// DRAW_TIMEOUT=300. A hand-derived vector table covers the first frames
// after reset; a behavioural model then checks every cycle of a randomized
// run, including a long draw_done stall and a reset taken in APPLY.
module tb_enemy_control;

    localparam int FRAME_TICKS  = 16;
    localparam int MOVE_DIV     = 2;
    localparam int DRAW_TIMEOUT = 300;

`ifdef ENEMY_CTRL_TIMEOUT_EN
    localparam bit WATCHDOG = 1'b1;
`else
    localparam bit WATCHDOG = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        respawn;
    logic [15:0] frame_count;
    logic [7:0]  overrun;
    logic        draw_error;

    enemy_control_if ctl_if ();

    enemy_control #(
        .FRAME_TICKS  (FRAME_TICKS),
        .MOVE_DIV     (MOVE_DIV),
        .DRAW_TIMEOUT (DRAW_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .respawn     (respawn),
        .bus         (ctl_if.master),
        .frame_count (frame_count),
        .overrun     (overrun),
        .draw_error  (draw_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_compared = 0;
    int n_failed   = 0;

    // Strobe bundle order {init, idle, gen_move, apply_move, draw, draw_request}.
    function automatic logic [5:0] dutStrobes();
        return {ctl_if.init, ctl_if.idle, ctl_if.gen_move,
                ctl_if.apply_move, ctl_if.draw, ctl_if.draw_request};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // after the following rising edge.
    task automatic applyStimulus(input logic rst, input logic r,
                                 input logic g, input logic d);
        @(negedge clock);
        reset             = rst;
        respawn           = r;
        ctl_if.draw_grant = g;
        ctl_if.draw_done  = d;
        @(posedge clock);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what the enemy is doing, tick schedule from the
    // cycle number, move decision from the count of consumed ticks.
    // ------------------------------------------------------------------
    typedef enum int {M_SPAWN, M_WAIT, M_MOVE1, M_MOVE2, M_REQ, M_DRAW} mode_t;

    mode_t       m_mode;
    int          m_edges;
    int          m_consumed;
    int          m_draw_cycles;
    bit          m_pend;
    bit          m_resp;
    logic [15:0] m_frames;
    int          m_dropped;
    bit          m_err;

    task automatic modelReset();
        m_mode        = M_SPAWN;
        m_edges       = 0;
        m_consumed    = 0;
        m_draw_cycles = 0;
        m_pend        = 1'b0;
        m_resp        = 1'b0;
        m_frames      = 16'd0;
        m_dropped     = 0;
        m_err         = 1'b0;
    endtask

    function automatic logic [5:0] modelStrobes(input mode_t m);
        case (m)
            M_SPAWN: return 6'b100000;
            M_WAIT:  return 6'b010000;
            M_MOVE1: return 6'b001000;
            M_MOVE2: return 6'b000100;
            M_REQ:   return 6'b010001;
            M_DRAW:  return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic modelStep(input logic rst, input logic r,
                             input logic g, input logic d);
        bit    tick_now;
        bit    respawning;
        bit    took;
        mode_t nm;
        if (rst) begin
            modelReset();
            return;
        end
        tick_now   = (m_edges % FRAME_TICKS) == (FRAME_TICKS - 1);
        respawning = m_resp || r;
        took       = 1'b0;
        nm         = m_mode;
        case (m_mode)
            M_SPAWN: nm = M_WAIT;
            M_WAIT: begin
                if (respawning) begin
                    nm = M_SPAWN;
                end else if (m_pend || tick_now) begin
                    took = 1'b1;
                    nm = ((m_consumed % MOVE_DIV) == MOVE_DIV - 1) ? M_MOVE1 : M_REQ;
                    m_consumed++;
                end
            end
            M_MOVE1: nm = M_MOVE2;
            M_MOVE2: nm = M_REQ;
            M_REQ: begin
                if (g) begin
                    nm = M_DRAW;
                    m_draw_cycles = 0;
                end
            end
            M_DRAW: begin
                m_draw_cycles++;
                if (d) begin
                    m_frames = m_frames + 16'd1;
                    nm = M_WAIT;
                end else if (WATCHDOG && m_draw_cycles >= DRAW_TIMEOUT) begin
                    m_err = 1'b1;
                    nm = M_WAIT;
                end
            end
            default: nm = M_SPAWN;
        endcase
        if (took) begin
            m_pend = m_pend && tick_now;
        end else if (tick_now) begin
            if (m_pend) m_dropped++;
            m_pend = 1'b1;
        end
        if (nm == M_SPAWN && m_mode != M_SPAWN) begin
            m_resp = 1'b0;
        end else if (r) begin
            m_resp = 1'b1;
        end
        m_edges++;
        m_mode = nm;
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".strobes"}, 32'(dutStrobes()), 32'(modelStrobes(m_mode)));
        checkOutput({tag, ".frame_count"}, 32'(frame_count), 32'(m_frames));
        checkOutput({tag, ".overrun"}, 32'(overrun),
                    32'((m_dropped > 255) ? 255 : m_dropped));
        checkOutput({tag, ".draw_error"}, 32'(draw_error), 32'(m_err));
    endtask

    task automatic stepAndCheck(input logic rst, input logic r, input logic g,
                                input logic d, input string tag);
        modelStep(rst, r, g, d);
        applyStimulus(rst, r, g, d);
        checkAgainstModel(tag);
    endtask

    // ------------------------------------------------------------------
    // Directed vectors from reset release. Each record is applied n times,
    // then the outputs are compared. Ticks land on edges 16, 32, 48, ...
    // ------------------------------------------------------------------
    typedef struct {
        int          n;
        logic        r;
        logic        g;
        logic        d;
        logic [5:0]  strobes;
        logic [15:0] frames;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    initial begin
        bit found;

        reset             = 1'b1;
        respawn           = 1'b0;
        ctl_if.draw_grant = 1'b0;
        ctl_if.draw_done  = 1'b0;

        vecs[0]  = '{1,  1'b0, 1'b1, 1'b0, 6'b010000, 16'd0}; // edge 1: IDLE
        vecs[1]  = '{14, 1'b0, 1'b1, 1'b0, 6'b010000, 16'd0}; // edge 15
        vecs[2]  = '{1,  1'b0, 1'b1, 1'b0, 6'b010001, 16'd0}; // edge 16: REQ, phase 0
        vecs[3]  = '{1,  1'b0, 1'b1, 1'b0, 6'b000011, 16'd0}; // edge 17: DRAW
        vecs[4]  = '{5,  1'b0, 1'b1, 1'b0, 6'b000011, 16'd0}; // edge 22: still DRAW
        vecs[5]  = '{1,  1'b0, 1'b1, 1'b1, 6'b010000, 16'd1}; // edge 23: done
        vecs[6]  = '{8,  1'b0, 1'b1, 1'b0, 6'b010000, 16'd1}; // edge 31
        vecs[7]  = '{1,  1'b0, 1'b1, 1'b0, 6'b001000, 16'd1}; // edge 32: GEN
        vecs[8]  = '{1,  1'b0, 1'b1, 1'b0, 6'b000100, 16'd1}; // edge 33: APPLY
        vecs[9]  = '{1,  1'b0, 1'b0, 1'b0, 6'b010001, 16'd1}; // edge 34: REQ
        vecs[10] = '{10, 1'b0, 1'b0, 1'b0, 6'b010001, 16'd1}; // edge 44: REQ held
        vecs[11] = '{1,  1'b0, 1'b1, 1'b0, 6'b000011, 16'd1}; // edge 45: grant -> DRAW
        vecs[12] = '{1,  1'b0, 1'b0, 1'b0, 6'b000011, 16'd1}; // grant drop ignored
        vecs[13] = '{1,  1'b0, 1'b0, 1'b1, 6'b010000, 16'd2}; // edge 47: done
        vecs[14] = '{1,  1'b0, 1'b0, 1'b1, 6'b010001, 16'd2}; // edge 48: REQ, done ignored
        vecs[15] = '{1,  1'b0, 1'b0, 1'b1, 6'b010001, 16'd2}; // done ignored in REQ
        vecs[16] = '{1,  1'b0, 1'b1, 1'b0, 6'b000011, 16'd2}; // edge 50: DRAW
        vecs[17] = '{1,  1'b0, 1'b0, 1'b1, 6'b010000, 16'd3}; // edge 51: done
        vecs[18] = '{1,  1'b1, 1'b0, 1'b0, 6'b100000, 16'd3}; // edge 52: respawn -> INIT
        vecs[19] = '{1,  1'b0, 1'b0, 1'b0, 6'b010000, 16'd3}; // edge 53: IDLE

        // Reset values.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.strobes", 32'(dutStrobes()), 32'h20);
        checkOutput("reset.frame_count", 32'(frame_count), 32'h0);
        checkOutput("reset.overrun", 32'(overrun), 32'h0);
        checkOutput("reset.draw_error", 32'(draw_error), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                applyStimulus(1'b0, vecs[i].r, vecs[i].g, vecs[i].d);
            end
            checkOutput($sformatf("vec%0d.strobes", i), 32'(dutStrobes()),
                        32'(vecs[i].strobes));
            checkOutput($sformatf("vec%0d.frame_count", i), 32'(frame_count),
                        32'(vecs[i].frames));
            checkOutput($sformatf("vec%0d.overrun", i), 32'(overrun), 32'h0);
        end

        // Randomized run against the model, with a 400-cycle draw_done
        // stall in the middle (grant held high so the stall lands in DRAW).
        modelStep(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAgainstModel("rand.reset");
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic g;
            logic d;
            r = ($urandom_range(0, 99) < 2);
            g = ($urandom_range(0, 99) < 70);
            d = ($urandom_range(0, 99) < 4);
            if (i >= 1000 && i < 1400) begin
                g = 1'b1;
                d = 1'b0;
            end
            stepAndCheck(1'b0, r, g, d, "rand");
        end

        // Reset taken while in APPLY.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            stepAndCheck(1'b0, 1'b0, 1'b1, ($urandom_range(0, 3) == 0), "seek");
            if (m_mode == M_MOVE2) found = 1'b1;
        end
        checkOutput("seek_apply_found", 32'(found), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("apply_reset.strobes", 32'(dutStrobes()), 32'h20);
        checkOutput("apply_reset.frame_count", 32'(frame_count), 32'h0);
        checkOutput("apply_reset.overrun", 32'(overrun), 32'h0);
        checkOutput("apply_reset.draw_error", 32'(draw_error), 32'h0);
        modelStep(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            stepAndCheck(1'b0, 1'b0, 1'b1, ($urandom_range(0, 7) == 0), "post");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
